imm_gen_pipe: RTL and testbench

- Parametrised, pipelined immediate generator for the decode stage.
- Covers all RV32I/RV64I immediate formats (I, S, B, U, J, shift-amount, CSR uimm) at XLEN width.
- Sits between fetch/decode and the execute register, and carries a sideband tag (PC) alongside the immediate.
- Uses a 2-entry elastic (skid) stage with valid/ready handshakes, a synchronous flush, and an illegal-format flag.

---
 rtl/imm_gen_pipe.sv | 116 +++++++++++
 tb/tb_imm_gen_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a 2-entry elastic output stage.
// The immediate is decoded before storage, so the output and skid entries both hold final values.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      Instr,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmOp,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    typedef enum logic [2:0] {
        SRC_I     = 3'b000,
        SRC_S     = 3'b001,
        SRC_B     = 3'b010,
        SRC_U     = 3'b011,
        SRC_J     = 3'b100,
        SRC_SHAMT = 3'b101,
        SRC_CSR   = 3'b110,
        SRC_RSVD  = 3'b111
    } imm_src_e;

    // Widen a 32-bit signed immediate to XLEN; works for XLEN=32 without a zero-width replicate.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN+31:0] wide;
        wide = {{XLEN{v[31]}}, v};
        return wide[XLEN-1:0];
    endfunction

    logic [XLEN-1:0]  imm_new;
    logic             ill_new;
    logic [5:0]       shamt;
    logic             unused_opcode;

    assign unused_opcode = ^Instr[6:0];
    assign shamt = (XLEN == 64) ? Instr[25:20] : {1'b0, Instr[24:20]};

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready depends on stored state only, and out_valid holds with stable data until taken.
    always_comb begin
        imm_new = '0;
        ill_new = 1'b0;
        case (imm_src_e'(ImmSrc))
            SRC_I:     imm_new = sext32({{20{Instr[31]}}, Instr[31:20]});
            SRC_S:     imm_new = sext32({{20{Instr[31]}}, Instr[31:25], Instr[11:7]});
            SRC_B:     imm_new = sext32({{19{Instr[31]}}, Instr[31], Instr[7],
                                         Instr[30:25], Instr[11:8], 1'b0});
            SRC_U:     imm_new = sext32({Instr[31:12], 12'b0});
            SRC_J:     imm_new = sext32({{11{Instr[31]}}, Instr[31], Instr[19:12],
                                         Instr[20], Instr[30:21], 1'b0});
            SRC_SHAMT: imm_new[5:0] = shamt;
            SRC_CSR:   imm_new[4:0] = Instr[19:15];
            SRC_RSVD:  ill_new = 1'b1;
            default:   ill_new = 1'b1;
        endcase
    end

    logic             sk_valid;
    logic [XLEN-1:0]  sk_imm;
    logic [TAG_W-1:0] sk_tag;
    logic             sk_ill;
    logic             accept;
    logic             or_free;

    assign in_ready = !sk_valid;
    assign accept   = in_valid && in_ready;
    assign or_free  = !out_valid || out_ready;

    // The skid entry is always older than anything at the input, so it refills the output first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ImmOp     <= '0;
            out_tag   <= '0;
            illegal   <= 1'b0;
            sk_valid  <= 1'b0;
            sk_imm    <= '0;
            sk_tag    <= '0;
            sk_ill    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            sk_valid  <= 1'b0;
        end else if (or_free) begin
            if (sk_valid) begin
                out_valid <= 1'b1;
                ImmOp     <= sk_imm;
                out_tag   <= sk_tag;
                illegal   <= sk_ill;
                sk_valid  <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                ImmOp     <= imm_new;
                out_tag   <= in_tag;
                illegal   <= ill_new;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            sk_valid <= 1'b1;
            sk_imm   <= imm_new;
            sk_tag   <= in_tag;
            sk_ill   <= ill_new;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: formats at XLEN 32/64, backpressure, flush, async reset,
// plus a random-ready stream scored against an expected queue.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] Instr;
    logic [2:0]  ImmSrc;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32, tag32;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    logic [31:0] tag64;

    int total = 0;
    int bad   = 0;
    logic        mon_en = 1'b0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .Instr(Instr), .ImmSrc(ImmSrc), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .ImmOp(imm32), .out_tag(tag32), .illegal(illegal32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .Instr(Instr), .ImmSrc(ImmSrc), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .ImmOp(imm64), .out_tag(tag64), .illegal(illegal64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected-queue monitor: each entry packs {tag, 32-bit immediate}.
    always @(negedge clk) begin
        if (mon_en && out_valid32 && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", 64'(out_valid32), 64'd0);
            end else begin
                check("sb_tag", 64'(tag32), 64'(exp_q[0][63:32]));
                check("sb_imm", 64'(imm32), 64'(exp_q[0][31:0]));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] v_instr[10];
    logic [2:0]  v_src[10];
    logic [63:0] v_e32[10];
    logic [63:0] v_e64[10];
    logic        v_ill[10];

    initial begin
        v_instr[0] = 32'hFFF00093; v_src[0] = 3'b000; v_e32[0] = 64'hFFFFFFFF; v_e64[0] = 64'hFFFFFFFFFFFFFFFF; v_ill[0] = 0;
        v_instr[1] = 32'h123450B7; v_src[1] = 3'b011; v_e32[1] = 64'h12345000; v_e64[1] = 64'h0000000012345000; v_ill[1] = 0;
        v_instr[2] = 32'hFE112E23; v_src[2] = 3'b001; v_e32[2] = 64'hFFFFFFFC; v_e64[2] = 64'hFFFFFFFFFFFFFFFC; v_ill[2] = 0;
        v_instr[3] = 32'hFE000CE3; v_src[3] = 3'b010; v_e32[3] = 64'hFFFFFFF8; v_e64[3] = 64'hFFFFFFFFFFFFFFF8; v_ill[3] = 0;
        v_instr[4] = 32'h0010006F; v_src[4] = 3'b100; v_e32[4] = 64'h00000800; v_e64[4] = 64'h0000000000000800; v_ill[4] = 0;
        v_instr[5] = 32'h800000B7; v_src[5] = 3'b011; v_e32[5] = 64'h80000000; v_e64[5] = 64'hFFFFFFFF80000000; v_ill[5] = 0;
        v_instr[6] = 32'h03F00013; v_src[6] = 3'b101; v_e32[6] = 64'h0000001F; v_e64[6] = 64'h000000000000003F; v_ill[6] = 0;
        v_instr[7] = 32'h800F8073; v_src[7] = 3'b110; v_e32[7] = 64'h0000001F; v_e64[7] = 64'h000000000000001F; v_ill[7] = 0;
        v_instr[8] = 32'hFFFFFFFF; v_src[8] = 3'b111; v_e32[8] = 64'h00000000; v_e64[8] = 64'h0000000000000000; v_ill[8] = 1;
        v_instr[9] = 32'h7FF00013; v_src[9] = 3'b000; v_e32[9] = 64'h000007FF; v_e64[9] = 64'h00000000000007FF; v_ill[9] = 0;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Instr = '0; ImmSrc = '0; in_tag = '0;

        // Reset state
        repeat (2) step();
        check("rst_out_valid", 64'(out_valid32), 64'd0);
        check("rst_imm32", 64'(imm32), 64'd0);
        check("rst_tag", 64'(tag32), 64'd0);
        check("rst_illegal", 64'(illegal32), 64'd0);
        check("rst_imm64", imm64, 64'd0);
        #2 rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 64'(in_ready32), 64'd1);

        // Back-to-back format vectors, one result per cycle
        for (int i = 0; i < 10; i++) begin
            Instr = v_instr[i]; ImmSrc = v_src[i]; in_tag = 32'h100 + 32'(i); in_valid = 1'b1;
            step();
            check($sformatf("fmt%0d_valid", i), 64'(out_valid32), 64'd1);
            check($sformatf("fmt%0d_imm32", i), 64'(imm32), v_e32[i]);
            check($sformatf("fmt%0d_tag", i), 64'(tag32), 64'h100 + 64'(i));
            check($sformatf("fmt%0d_ill32", i), 64'(illegal32), 64'(v_ill[i]));
            check($sformatf("fmt%0d_imm64", i), imm64, v_e64[i]);
            check($sformatf("fmt%0d_ill64", i), 64'(illegal64), 64'(v_ill[i]));
        end
        in_valid = 1'b0;
        step();
        check("idle_out_valid", 64'(out_valid32), 64'd0);
        check("idle_imm_hold", 64'(imm32), 64'h7FF);

        // Backpressure: tags 1,2,3 with the consumer stalled
        out_ready = 1'b0; Instr = 32'h00100013; ImmSrc = 3'b000;
        in_tag = 32'd1; in_valid = 1'b1;
        step();
        check("bp_or_tag1", 64'(tag32), 64'd1);
        check("bp_in_ready_1", 64'(in_ready32), 64'd1);
        in_tag = 32'd2;
        step();
        check("bp_hold_tag1", 64'(tag32), 64'd1);
        check("bp_in_ready_0", 64'(in_ready32), 64'd0);
        in_tag = 32'd3;
        step();
        check("bp_stall_tag1", 64'(tag32), 64'd1);
        check("bp_stall_valid", 64'(out_valid32), 64'd1);
        check("bp_stall_ready", 64'(in_ready32), 64'd0);
        step();
        check("bp_stable_tag1", 64'(tag32), 64'd1);
        out_ready = 1'b1;
        step();
        check("bp_drain_tag2", 64'(tag32), 64'd2);
        check("bp_drain_valid2", 64'(out_valid32), 64'd1);
        check("bp_drain_ready", 64'(in_ready32), 64'd1);
        step();
        check("bp_drain_tag3", 64'(tag32), 64'd3);
        check("bp_drain_valid3", 64'(out_valid32), 64'd1);
        in_valid = 1'b0;
        step();
        check("bp_empty", 64'(out_valid32), 64'd0);

        // Flush with both entries full and an input pending
        out_ready = 1'b0; in_tag = 32'hA1; in_valid = 1'b1;
        step();
        in_tag = 32'hA2;
        step();
        check("fl_full_ready", 64'(in_ready32), 64'd0);
        in_tag = 32'hA3; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 64'(out_valid32), 64'd0);
        check("fl_in_ready", 64'(in_ready32), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("fl_quiet%0d", i), 64'(out_valid32), 64'd0);
        end

        // Flush drops an input accepted in the same cycle
        out_ready = 1'b0; in_tag = 32'hB1; in_valid = 1'b1;
        step();
        in_tag = 32'hB2; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fd_out_valid", 64'(out_valid32), 64'd0);
        check("fd_in_ready", 64'(in_ready32), 64'd1);
        step();
        check("fd_no_b2", 64'(out_valid32), 64'd0);
        out_ready = 1'b1; in_tag = 32'hC1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("fd_c1_valid", 64'(out_valid32), 64'd1);
        check("fd_c1_tag", 64'(tag32), 64'hC1);
        step();

        // Asynchronous reset between clock edges
        out_ready = 1'b0; Instr = 32'hFFF00093; ImmSrc = 3'b000; in_tag = 32'hD1; in_valid = 1'b1;
        step();
        check("ar_pre_valid", 64'(out_valid32), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(out_valid32), 64'd0);
        check("ar_imm32", 64'(imm32), 64'd0);
        check("ar_tag", 64'(tag32), 64'd0);
        check("ar_imm64", imm64, 64'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();
        check("ar_in_ready", 64'(in_ready32), 64'd1);
        check("ar_idle", 64'(out_valid32), 64'd0);
        out_ready = 1'b1; Instr = 32'h123450B7; ImmSrc = 3'b011; in_tag = 32'hD2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("ar_first_valid", 64'(out_valid32), 64'd1);
        check("ar_first_tag", 64'(tag32), 64'hD2);
        check("ar_first_imm", 64'(imm32), 64'h12345000);
        step();

        // Random-ready stream against the expected queue
        mon_en = 1'b1;
        ImmSrc = 3'b000;
        for (int n = 0; n < 40; n++) begin
            logic [11:0] t12;
            logic        acc;
            int          guard;
            t12 = 12'($urandom_range(0, 4095));
            Instr = {t12, 20'h00013};
            in_tag = 32'h200 + 32'(n);
            in_valid = 1'b1;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 100) begin
                @(negedge clk);
                acc = in_ready32;
                if (acc) exp_q.push_back({in_tag, {{20{t12[11]}}, t12}});
                step();
                out_ready = 1'($urandom_range(0, 1));
                guard++;
            end
            if (!acc) check("sb_accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
